// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, 1-cycle-latency RAM.
// Fetch (I) and load/store (D) ports share the RAM; read responses are routed
// back to the issuing port, and saturating stall counters aid perf debug.
module mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_en,
    output logic [DATA_W/8-1:0]   m_we,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic [CNT_W-1:0]      i_stall_cnt,
    output logic [CNT_W-1:0]      d_stall_cnt
);

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    port_e            last_q, last_d;
    logic             rsp_i_q, rsp_i_d;
    logic             rsp_d_q, rsp_d_d;
    logic [CNT_W-1:0] i_stall_q, i_stall_d;
    logic [CNT_W-1:0] d_stall_q, d_stall_d;

    // Zero-latency grant: a lone requester wins, contention goes to the port not served last.
    always_comb begin
        i_gnt = i_req && (!d_req || (last_q == PORT_D));
        d_gnt = d_req && (!i_req || (last_q == PORT_I));
    end

    // RAM drive follows the grant; byte writes only for a granted D store.
    always_comb begin
        m_en    = i_gnt | d_gnt;
        m_addr  = d_gnt ? d_addr : i_addr;
        m_we    = (d_gnt && d_we) ? d_be : '0;
        m_wdata = d_wdata;
    end

    // Next state: fairness pointer, response-pending flags, saturating stall counters.
    always_comb begin
        last_d = last_q;
        if (d_gnt) begin
            last_d = PORT_D;
        end else if (i_gnt) begin
            last_d = PORT_I;
        end

        rsp_i_d = i_gnt;
        rsp_d_d = d_gnt && !d_we;

        i_stall_d = i_stall_q;
        if (i_req && !i_gnt && (i_stall_q != '1)) begin
            i_stall_d = i_stall_q + CNT_ONE;
        end

        d_stall_d = d_stall_q;
        if (d_req && !d_gnt && (d_stall_q != '1)) begin
            d_stall_d = d_stall_q + CNT_ONE;
        end
    end

    // State registers; reset leaves last=D so I wins the first contended cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q    <= PORT_D;
            rsp_i_q   <= 1'b0;
            rsp_d_q   <= 1'b0;
            i_stall_q <= '0;
            d_stall_q <= '0;
        end else begin
            last_q    <= last_d;
            rsp_i_q   <= rsp_i_d;
            rsp_d_q   <= rsp_d_d;
            i_stall_q <= i_stall_d;
            d_stall_q <= d_stall_d;
        end
    end

    // Read data is shared and unqualified; rvalid tells each port when it is theirs.
    always_comb begin
        i_rvalid    = rsp_i_q;
        d_rvalid    = rsp_d_q;
        i_rdata     = m_rdata;
        d_rdata     = m_rdata;
        i_stall_cnt = i_stall_q;
        d_stall_cnt = d_stall_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level
// reference model (round-robin choice, shadow memory, stall tallies).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, d_req, d_we;
    logic [11:0] i_addr, d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;

    logic        i_gnt, d_gnt, i_rvalid, d_rvalid, m_en;
    logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
    logic [3:0]  m_we;
    logic [11:0] m_addr;
    logic [15:0] i_stall_cnt, d_stall_cnt;

    logic        s_i_gnt, s_d_gnt, s_i_rvalid, s_d_rvalid, s_m_en;
    logic [31:0] s_i_rdata, s_d_rdata, s_m_wdata;
    logic [3:0]  s_m_we;
    logic [11:0] s_m_addr;
    logic [3:0]  s_i_stall, s_d_stall;

    always #5 clk = ~clk;

    mem_arbiter u_dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    mem_arbiter #(.ADDR_W(12), .DATA_W(32), .CNT_W(4)) u_sat (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(s_i_gnt), .i_rvalid(s_i_rvalid), .i_rdata(s_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
        .m_en(s_m_en), .m_we(s_m_we), .m_addr(s_m_addr), .m_wdata(s_m_wdata), .m_rdata(m_rdata),
        .i_stall_cnt(s_i_stall), .d_stall_cnt(s_d_stall)
    );

    // Environment RAM: 1-cycle read latency, byte-masked writes, rdata held otherwise.
    logic [31:0] ram [4096];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we == 4'b0000) m_rdata <= ram[m_addr];
            for (int b = 0; b < 4; b++)
                if (m_we[b]) ram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [4096];
    int          ref_last;      // 0 = I served last, 1 = D served last
    bit          e_iv, e_dv;
    logic [31:0] e_ird, e_drd;
    int          i_stalls, d_stalls;
    bit          prev_gi, prev_gd;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock cycle: inputs are already driven; check at negedge, advance the model.
    task automatic step();
        bit         eg_i, eg_d;
        logic [3:0] ewe;
        if (!resetn) begin
            ref_last = 1; e_iv = 0; e_dv = 0; i_stalls = 0; d_stalls = 0;
        end
        @(negedge clk);
        if (i_req && d_req) begin
            eg_i = (ref_last == 1);
            eg_d = !eg_i;
        end else begin
            eg_i = i_req;
            eg_d = d_req;
        end
        ewe = (eg_d && d_we) ? d_be : 4'b0000;
        chk("i_gnt", i_gnt, eg_i);
        chk("d_gnt", d_gnt, eg_d);
        chk("m_en", m_en, eg_i | eg_d);
        chk("m_we", m_we, ewe);
        if (eg_i | eg_d) chk("m_addr", m_addr, eg_d ? d_addr : i_addr);
        if (eg_d && d_we) chk("m_wdata", m_wdata, d_wdata);
        chk("i_rvalid", i_rvalid, e_iv);
        chk("d_rvalid", d_rvalid, e_dv);
        if (e_iv) chk("i_rdata", i_rdata, e_ird);
        if (e_dv) chk("d_rdata", d_rdata, e_drd);
        chk("i_stall_cnt", i_stall_cnt, sat(i_stalls, 65535));
        chk("d_stall_cnt", d_stall_cnt, sat(d_stalls, 65535));
        chk("sat_i_gnt", s_i_gnt, eg_i);
        chk("sat_d_gnt", s_d_gnt, eg_d);
        chk("sat_m_en", s_m_en, eg_i | eg_d);
        chk("sat_m_we", s_m_we, ewe);
        chk("sat_rvalid", {s_i_rvalid, s_d_rvalid}, {e_iv, e_dv});
        chk("sat_i_stall", s_i_stall, sat(i_stalls, 15));
        chk("sat_d_stall", s_d_stall, sat(d_stalls, 15));
        prev_gi = eg_i;
        prev_gd = eg_d;
        if (resetn) begin
            if (eg_i | eg_d) ref_last = eg_d ? 1 : 0;
            e_iv = eg_i;
            if (eg_i) e_ird = ref_mem[i_addr];
            e_dv = eg_d && !d_we;
            if (e_dv) e_drd = ref_mem[d_addr];
            if (i_req && !eg_i) i_stalls++;
            if (d_req && !eg_d) d_stalls++;
        end
        if (eg_d && d_we)
            for (int b = 0; b < 4; b++)
                if (d_be[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req = 0; d_req = 0; d_we = 0; d_be = 4'b0000;
    endtask

    task automatic reset_pulse();
        idle();
        resetn = 0;
        step();
        resetn = 1;
        step();
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) begin
            logic [31:0] v;
            v = (k == 16) ? 32'h11223344 : $urandom;
            ram[k] = v;
            ref_mem[k] = v;
        end
        ref_last = 1; e_iv = 0; e_dv = 0; i_stalls = 0; d_stalls = 0;
        prev_gi = 0; prev_gd = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        idle();
        resetn = 0;
        @(posedge clk);
        #1;

        // Reset state, then a first fetch from address 0.
        repeat (3) step();
        chk("rst_i_rvalid", i_rvalid, 1'b0);
        chk("rst_d_stall", d_stall_cnt, 16'd0);
        resetn = 1;
        step();
        i_req = 1; i_addr = 12'h000;
        step();
        i_req = 0;
        step();

        // Continuous contention with D loads: alternating grants, 4 stalls each.
        reset_pulse();
        i_addr = 12'h100; d_addr = 12'h200;
        for (int c = 0; c < 8; c++) begin
            i_req = 1; d_req = 1; d_we = 0;
            step();
            if (prev_gi) i_addr = i_addr + 12'd1;
            if (prev_gd) d_addr = d_addr + 12'd1;
        end
        idle();
        step();
        chk("cont_i_stall", i_stall_cnt, 16'd4);
        chk("cont_d_stall", d_stall_cnt, 16'd4);

        // Partial store then load of the same word.
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 12'h010; d_wdata = 32'hDEADBEEF;
        step();
        d_we = 0; d_be = 4'b0000;
        step();
        idle();
        step();
        chk("st_ld_rdata", d_rdata, 32'h1122BEEF);

        // Cancel: I raised while D wins, then dropped before any grant.
        reset_pulse();
        i_req = 1; i_addr = 12'h030;
        step();
        i_req = 1; i_addr = 12'h031; d_req = 1; d_we = 0; d_addr = 12'h040;
        step();
        i_req = 0; d_addr = 12'h041;
        step();
        idle();
        step();
        chk("cancel_i_stall", i_stall_cnt, 16'd1);

        // Saturation: 20 D stall cycles under contention.
        reset_pulse();
        for (int c = 0; c < 40; c++) begin
            i_req = 1; d_req = 1; d_we = 0;
            i_addr = 12'h300; d_addr = 12'h400;
            step();
        end
        idle();
        step();
        chk("sat4_d_stall", s_d_stall, 4'd15);
        chk("sat16_d_stall", d_stall_cnt, 16'd20);
        for (int c = 0; c < 4; c++) begin
            i_req = 1; d_req = 1;
            step();
        end
        idle();
        step();
        chk("sat4_d_hold", s_d_stall, 4'd15);

        // Reset while a fetch response is pending.
        i_req = 1; i_addr = 12'h020;
        step();
        idle();
        resetn = 0;
        #1;
        chk("midrst_i_rvalid", i_rvalid, 1'b0);
        step();
        step();
        resetn = 1;
        i_req = 1; d_req = 1; d_we = 0; i_addr = 12'h021; d_addr = 12'h022;
        #1;
        chk("post_rst_i_wins", i_gnt, 1'b1);
        step();
        idle();
        step();

        // Randomized traffic obeying the hold-until-grant protocol, with cancels.
        for (int c = 0; c < 3000; c++) begin
            if (i_req && !prev_gi) begin
                if ($urandom_range(7) == 0) i_req = 0;
            end else begin
                i_req  = 1'($urandom_range(1));
                i_addr = 12'($urandom_range(31));
            end
            if (d_req && !prev_gd) begin
                if ($urandom_range(7) == 0) d_req = 0;
            end else begin
                d_req   = 1'($urandom_range(1));
                d_we    = 1'($urandom_range(1));
                d_be    = 4'($urandom_range(15));
                d_addr  = 12'($urandom_range(31));
                d_wdata = $urandom;
            end
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
